// File: rtl/hyst_pkg.sv
// Shared types and reset defaults for the multi-channel hysteresis interlock.
package hyst_pkg;

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_ARM_GO   = 2'd1,
        ST_GO       = 2'd2,
        ST_ARM_STOP = 2'd3
    } hyst_state_t;

    localparam int unsigned GO_THR_DEF   = 300;
    localparam int unsigned STOP_THR_DEF = 1000;
    localparam int unsigned DEB_DEF      = 3;

    // A permit is granted while the channel is released or arming to stop.
    function automatic logic permit_of(input hyst_state_t s);
        return (s == ST_GO) || (s == ST_ARM_STOP);
    endfunction

endpackage

// File: rtl/hyst_channel.sv
// One interlock channel: threshold compare, debounce counter and 4-state FSM.
module hyst_channel
    import hyst_pkg::*;
#(
    parameter int unsigned DW   = 12,
    parameter int unsigned CNTW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,        // consume x this cycle
    input  logic            revert,     // accepted config write: drop any debounce progress
    input  logic [DW-1:0]   x,
    input  logic [DW-1:0]   go_thr,
    input  logic [DW-1:0]   stop_thr,
    input  logic [CNTW-1:0] deb_eff,
    output logic            permit,
    output logic            chg_pulse,
    output logic            permit_nxt
);

    hyst_state_t     state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt, cnt_inc;
    logic            q_go, q_stop;

    // Inclusive boundaries; anything strictly between is the dead band.
    assign q_go    = (x <= go_thr);
    assign q_stop  = (x >= stop_thr);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNTW'(1);

    // Next-state / counter decode; holds completely when neither strobe is set.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (revert) begin
            cnt_nxt = '0;
            if (state == ST_ARM_GO)   state_nxt = ST_STOP;
            if (state == ST_ARM_STOP) state_nxt = ST_GO;
        end else if (adv) begin
            case (state)
                ST_STOP: begin
                    if (q_go) begin
                        cnt_nxt   = CNTW'(1);
                        state_nxt = (deb_eff == CNTW'(1)) ? ST_GO : ST_ARM_GO;
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                ST_ARM_GO: begin
                    if (q_go) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == deb_eff) state_nxt = ST_GO;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = ST_STOP;
                    end
                end
                ST_GO: begin
                    if (q_stop) begin
                        cnt_nxt   = CNTW'(1);
                        state_nxt = (deb_eff == CNTW'(1)) ? ST_STOP : ST_ARM_STOP;
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                default: begin // ST_ARM_STOP
                    if (q_stop) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == deb_eff) state_nxt = ST_STOP;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = ST_GO;
                    end
                end
            endcase
        end
    end

    assign permit_nxt = permit_of(state_nxt);

    // State, counter, registered permit and its change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STOP;
            cnt       <= '0;
            permit    <= 1'b0;
            chg_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            permit    <= permit_nxt;
            chg_pulse <= permit_nxt ^ permit;
        end
    end

endmodule

// File: rtl/hysteresis_ctrl_multi.sv
// Multi-channel forward-motion interlock: shared runtime config plus NCH channels.
module hysteresis_ctrl_multi
    import hyst_pkg::*;
#(
    parameter int unsigned NCH          = 4,
    parameter int unsigned DW           = 12,
    parameter int unsigned CNTW         = 4,
    parameter int unsigned GO_THR_RST   = GO_THR_DEF,
    parameter int unsigned STOP_THR_RST = STOP_THR_DEF,
    parameter int unsigned DEB_RST      = DEB_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [NCH*DW-1:0] sample_data,
    input  logic              cfg_wr,
    input  logic [DW-1:0]     cfg_go_thr,
    input  logic [DW-1:0]     cfg_stop_thr,
    input  logic [CNTW-1:0]   cfg_deb,
    output logic              cfg_err,
    output logic [NCH-1:0]    can_move_fwd,
    output logic [NCH-1:0]    chg_pulse,
    output logic              all_fwd
);

    logic [DW-1:0]   go_thr, stop_thr;
    logic [CNTW-1:0] deb, deb_eff;
    logic            cfg_ok, cfg_accept, adv;
    logic [NCH-1:0]  permit_nxt;

    assign cfg_ok     = (cfg_go_thr < cfg_stop_thr);
    assign cfg_accept = cfg_wr && cfg_ok;
    // A config write steals the cycle: any coincident sample is dropped everywhere.
    assign adv        = sample_valid && !cfg_wr;
    assign deb_eff    = (deb == '0) ? CNTW'(1) : deb;

    // Shared thresholds / debounce and the sticky reject flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            go_thr   <= DW'(GO_THR_RST);
            stop_thr <= DW'(STOP_THR_RST);
            deb      <= CNTW'(DEB_RST);
            cfg_err  <= 1'b0;
        end else if (cfg_wr) begin
            if (cfg_ok) begin
                go_thr   <= cfg_go_thr;
                stop_thr <= cfg_stop_thr;
                deb      <= cfg_deb;
                cfg_err  <= 1'b0;
            end else begin
                cfg_err  <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        hyst_channel #(.DW(DW), .CNTW(CNTW)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv),
            .revert     (cfg_accept),
            .x          (sample_data[i*DW +: DW]),
            .go_thr     (go_thr),
            .stop_thr   (stop_thr),
            .deb_eff    (deb_eff),
            .permit     (can_move_fwd[i]),
            .chg_pulse  (chg_pulse[i]),
            .permit_nxt (permit_nxt[i])
        );
    end

    // Aggregate permit taken from next-state so it lines up with can_move_fwd.
    always_ff @(posedge clk) begin
        if (rst) all_fwd <= 1'b0;
        else     all_fwd <= &permit_nxt;
    end

endmodule

// File: tb/tb_hysteresis_ctrl_multi.sv
// Self-checking bench for hysteresis_ctrl_multi: directed scenarios plus random run.
module tb_hysteresis_ctrl_multi;

    localparam int NCH  = 4;
    localparam int DW   = 12;
    localparam int CNTW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic [NCH*DW-1:0] sample_data;
    logic              cfg_wr;
    logic [DW-1:0]     cfg_go_thr, cfg_stop_thr;
    logic [CNTW-1:0]   cfg_deb;
    logic              cfg_err;
    logic [NCH-1:0]    can_move_fwd, chg_pulse;
    logic              all_fwd;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hysteresis_ctrl_multi dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .cfg_wr       (cfg_wr),
        .cfg_go_thr   (cfg_go_thr),
        .cfg_stop_thr (cfg_stop_thr),
        .cfg_deb      (cfg_deb),
        .cfg_err      (cfg_err),
        .can_move_fwd (can_move_fwd),
        .chg_pulse    (chg_pulse),
        .all_fwd      (all_fwd)
    );

    // Reference model: a permit bit plus a run-length of consecutive samples
    // that argue for flipping it.
    bit m_perm[NCH];
    bit m_chg[NCH];
    int m_run[NCH];
    int m_go = 300, m_stop = 1000, m_deb = 3;
    bit m_err = 0;

    function automatic logic [NCH-1:0] exp_perm();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_perm[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_chg();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_chg[i];
        return v;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) m_chg[i] = 0;
        if (rst) begin
            m_go = 300; m_stop = 1000; m_deb = 3; m_err = 0;
            for (int i = 0; i < NCH; i++) begin m_perm[i] = 0; m_run[i] = 0; end
        end else if (cfg_wr) begin
            if (cfg_go_thr < cfg_stop_thr) begin
                m_go = int'(cfg_go_thr); m_stop = int'(cfg_stop_thr);
                m_deb = (cfg_deb == 0) ? 1 : int'(cfg_deb);
                m_err = 0;
                for (int i = 0; i < NCH; i++) m_run[i] = 0;
            end else begin
                m_err = 1;
            end
        end else if (sample_valid) begin
            for (int i = 0; i < NCH; i++) begin
                int x;
                bit q;
                x = int'(sample_data[i*DW +: DW]);
                q = m_perm[i] ? (x >= m_stop) : (x <= m_go);
                if (q) begin
                    m_run[i]++;
                    if (m_run[i] >= m_deb) begin
                        m_perm[i] = !m_perm[i];
                        m_run[i]  = 0;
                        m_chg[i]  = 1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    // One clock: model consumes the same inputs the DUT sees, outputs sampled #1 later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NCH; i++) sample_data[i*DW +: DW] = DW'(v);
    endtask

    task automatic do_cfg(input int go, input int stop, input int deb);
        cfg_wr = 1; cfg_go_thr = DW'(go); cfg_stop_thr = DW'(stop); cfg_deb = CNTW'(deb);
        tick();
        cfg_wr = 0;
    endtask

    task automatic test_reset();
        rst = 1; sample_valid = 0; cfg_wr = 0; set_all(0);
        cfg_go_thr = 0; cfg_stop_thr = 0; cfg_deb = 0;
        tick(); tick();
        rst = 0;
        tick();
        n_chk++;
        if ({can_move_fwd, chg_pulse, all_fwd, cfg_err} !== '0)
            $display("FAIL reset: perm=%b chg=%b all=%b err=%b expected all zero",
                     can_move_fwd, chg_pulse, all_fwd, cfg_err);
        else n_pass++;
    endtask

    task automatic test_rise();
        set_all(500);
        sample_data[0 +: DW] = DW'(200);
        sample_valid = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (can_move_fwd[0] !== (k == 2) || chg_pulse[0] !== (k == 2))
                $display("FAIL rise[%0d]: perm0=%b chg0=%b expected %b", k,
                         can_move_fwd[0], chg_pulse[0], k == 2);
            else n_pass++;
        end
        sample_valid = 0;
        tick();
        n_chk++;
        if (can_move_fwd !== 4'b0001 || chg_pulse !== 4'b0000)
            $display("FAIL rise_hold: perm=%b chg=%b expected 0001/0000", can_move_fwd, chg_pulse);
        else n_pass++;
    endtask

    task automatic test_fall();
        int seq[5] = '{1000, 500, 1000, 1000, 1000};
        sample_valid = 1;
        for (int k = 0; k < 5; k++) begin
            sample_data[0 +: DW] = DW'(seq[k]);
            tick();
            n_chk++;
            if (can_move_fwd[0] !== (k != 4) || chg_pulse[0] !== (k == 4))
                $display("FAIL fall[%0d]: perm0=%b chg0=%b expected perm %b", k,
                         can_move_fwd[0], chg_pulse[0], k != 4);
            else n_pass++;
        end
        sample_valid = 0;
    endtask

    task automatic test_boundaries();
        int       xs[6]   = '{301, 300, 999, 1000, 1000, 1000};
        bit       vs[6]   = '{1, 1, 1, 0, 0, 1};
        bit       ep[6]   = '{0, 1, 1, 1, 1, 0};
        do_cfg(300, 1000, 1);
        for (int k = 0; k < 6; k++) begin
            sample_data[0 +: DW] = DW'(xs[k]);
            sample_valid = vs[k];
            tick();
            n_chk++;
            if (can_move_fwd[0] !== ep[k] || can_move_fwd !== exp_perm() || chg_pulse !== exp_chg())
                $display("FAIL bound[%0d] x=%0d: perm=%b chg=%b expected perm0 %b", k, xs[k],
                         can_move_fwd, chg_pulse, ep[k]);
            else n_pass++;
        end
        sample_valid = 0;
    endtask

    task automatic test_cfg();
        do_cfg(300, 1000, 3);
        do_cfg(800, 700, 3);
        n_chk++;
        if (cfg_err !== 1'b1) $display("FAIL cfg_reject: cfg_err=%b expected 1", cfg_err);
        else n_pass++;
        sample_valid = 1;
        sample_data[0 +: DW] = DW'(700);
        tick();
        sample_data[0 +: DW] = DW'(200);
        tick(); tick();
        n_chk++;
        if (can_move_fwd[0] !== 1'b0 || cfg_err !== 1'b1)
            $display("FAIL cfg_oldthr: perm0=%b err=%b expected 0/1", can_move_fwd[0], cfg_err);
        else n_pass++;
        sample_valid = 0;
        do_cfg(100, 900, 3);
        n_chk++;
        if (cfg_err !== 1'b0 || can_move_fwd[0] !== 1'b0 || chg_pulse !== '0)
            $display("FAIL cfg_accept: err=%b perm0=%b chg=%b expected 0/0/0",
                     cfg_err, can_move_fwd[0], chg_pulse);
        else n_pass++;
        sample_valid = 1;
        sample_data[0 +: DW] = DW'(50);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (can_move_fwd[0] !== (k == 2))
                $display("FAIL cfg_revert[%0d]: perm0=%b expected %b", k, can_move_fwd[0], k == 2);
            else n_pass++;
        end
        sample_valid = 0;
    endtask

    task automatic test_collision();
        rst = 1; tick(); rst = 0;
        set_all(500);
        sample_data[0 +: DW] = DW'(0);
        sample_valid = 1;
        do_cfg(300, 1000, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (can_move_fwd[0] !== (k == 2))
                $display("FAIL collide[%0d]: perm0=%b expected %b", k, can_move_fwd[0], k == 2);
            else n_pass++;
        end
        sample_valid = 0;
    endtask

    task automatic test_random();
        int pick;
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            cfg_wr       = ($urandom_range(0, 39) == 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            cfg_go_thr   = DW'($urandom_range(0, 2000));
            if ($urandom_range(0, 3) == 0) cfg_stop_thr = cfg_go_thr - DW'($urandom_range(0, 50));
            else cfg_stop_thr = cfg_go_thr + DW'($urandom_range(1, 1500));
            cfg_deb      = CNTW'($urandom_range(0, 4));
            for (int i = 0; i < NCH; i++) begin
                pick = $urandom_range(0, 6);
                case (pick)
                    0: sample_data[i*DW +: DW] = DW'(m_go);
                    1: sample_data[i*DW +: DW] = DW'(m_go + 1);
                    2: sample_data[i*DW +: DW] = DW'(m_stop);
                    3: sample_data[i*DW +: DW] = DW'(m_stop - 1);
                    4: sample_data[i*DW +: DW] = DW'($urandom_range(0, m_go));
                    5: sample_data[i*DW +: DW] = DW'($urandom_range(m_stop, 4095));
                    default: sample_data[i*DW +: DW] = DW'($urandom_range(0, 4095));
                endcase
            end
            tick();
            n_chk++;
            if (can_move_fwd !== exp_perm() || chg_pulse !== exp_chg() ||
                all_fwd !== (&exp_perm()) || cfg_err !== m_err)
                $display("FAIL random[%0d]: perm=%b/%b chg=%b/%b all=%b/%b err=%b/%b (dut/exp)", n,
                         can_move_fwd, exp_perm(), chg_pulse, exp_chg(),
                         all_fwd, &exp_perm(), cfg_err, m_err);
            else n_pass++;
        end
        rst = 0; cfg_wr = 0; sample_valid = 0;

        // Reset in the middle of arming discards progress on every channel.
        rst = 1; tick(); rst = 0;
        set_all(0);
        sample_valid = 1;
        tick(); tick();
        rst = 1; tick(); rst = 0;
        n_chk++;
        if (can_move_fwd !== '0 || all_fwd !== 1'b0)
            $display("FAIL rst_midarm: perm=%b all=%b expected 0", can_move_fwd, all_fwd);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (can_move_fwd !== {NCH{k == 2}} || all_fwd !== (k == 2))
                $display("FAIL rst_rearm[%0d]: perm=%b all=%b expected %b", k,
                         can_move_fwd, all_fwd, k == 2);
            else n_pass++;
        end
        sample_valid = 0;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_boundaries();
        test_cfg();
        test_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
